// File: rtl/mvu_pkg.sv
// Shared types and elaboration helpers for the matrix-vector unit.
// Holds the FSM state encoding, counter-width helpers and a parameter legality check.
package mvu_pkg;

    typedef enum logic [1:0] {
        LOAD_W  = 2'd0,
        RX_IN   = 2'd1,
        COMPUTE = 2'd2,
        EMIT    = 2'd3
    } mvu_state_e;

    // A counter over n states needs at least one bit, even when n == 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int fold_w(input int c_in, input int simd);
        return cnt_w(c_in / simd);
    endfunction

    function automatic int grp_w(input int c_out, input int pe);
        return cnt_w(c_out / pe);
    endfunction

    function automatic bit params_ok(input int c_in, input int c_out, input int simd,
                                     input int pe, input int in_w, input int w_w,
                                     input int acc_w);
        return (simd > 0) && (pe > 0) && (c_in % simd == 0) && (c_out % pe == 0) &&
               (acc_w >= in_w + w_w + $clog2(c_in));
    endfunction

endpackage

// File: rtl/mvu_pe_array.sv
// PE x SIMD multiplier array feeding PE registered accumulators.
// Operands are widened by one bit so signed and unsigned inputs share one signed multiplier.
module mvu_pe_array
    import mvu_pkg::*;
#(
    parameter int SIMD      = 8,
    parameter int PE        = 16,
    parameter int IN_WIDTH  = 8,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int IN_SIGNED = 1,
    parameter int W_SIGNED  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_en,
    input  logic                                  i_clr,
    input  logic [SIMD*IN_WIDTH-1:0]              i_x,
    input  logic [PE-1:0][SIMD*W_WIDTH-1:0]       i_w,
    output logic [PE-1:0][ACC_WIDTH-1:0]          o_acc
);
    localparam int PW = IN_WIDTH + W_WIDTH + 2;

    logic [PE-1:0][SIMD-1:0][ACC_WIDTH-1:0] w_term;
    logic [PE-1:0][ACC_WIDTH-1:0]           w_dot;
    logic [PE-1:0][ACC_WIDTH-1:0]           r_acc;

    for (genvar p = 0; p < PE; p++) begin : g_pe
        for (genvar s = 0; s < SIMD; s++) begin : g_mac
            logic signed [IN_WIDTH:0] w_xe;
            logic signed [W_WIDTH:0]  w_we;
            logic signed [PW-1:0]     w_prod;
            assign w_xe = {(IN_SIGNED != 0) & i_x[s*IN_WIDTH+IN_WIDTH-1],
                           i_x[s*IN_WIDTH +: IN_WIDTH]};
            assign w_we = {(W_SIGNED != 0) & i_w[p][s*W_WIDTH+W_WIDTH-1],
                           i_w[p][s*W_WIDTH +: W_WIDTH]};
            assign w_prod = w_xe * w_we;
            // Sign-extend (or truncate) into the accumulator; sums wrap modulo 2^ACC_WIDTH.
            assign w_term[p][s] = ACC_WIDTH'(w_prod);
        end
    end

    always_comb begin
        w_dot = '0;
        for (int p = 0; p < PE; p++) begin
            for (int s = 0; s < SIMD; s++) begin
                w_dot[p] = w_dot[p] + w_term[p][s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            for (int p = 0; p < PE; p++) begin
                r_acc[p] <= (i_clr ? '0 : r_acc[p]) + w_dot[p];
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/interface_relationships_mvu.sv
// Streaming matrix-vector unit: loads a weight matrix, then folds SIMD-wide input vectors
// through PE parallel dot products. Define MVU_RELU_EN to clamp negative outputs to zero.
module interface_relationships_mvu
    import mvu_pkg::*;
#(
    parameter int C_IN      = 32,
    parameter int C_OUT     = 64,
    parameter int SIMD      = 8,
    parameter int PE        = 16,
    parameter int IN_WIDTH  = 8,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 32,
    parameter int IN_SIGNED = 1,
    parameter int W_SIGNED  = 1
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [SIMD*W_WIDTH-1:0]  s_axis_weights_tdata,
    input  logic                     s_axis_weights_tvalid,
    output logic                     s_axis_weights_tready,
    input  logic                     s_axis_weights_tlast,
    input  logic [SIMD*IN_WIDTH-1:0] s_axis_input_tdata,
    input  logic                     s_axis_input_tvalid,
    output logic                     s_axis_input_tready,
    input  logic                     s_axis_input_tlast,
    output logic [PE*ACC_WIDTH-1:0]  m_axis_output_tdata,
    output logic                     m_axis_output_tvalid,
    input  logic                     m_axis_output_tready,
    output logic                     m_axis_output_tlast,
    output logic                     err_framing
);
    localparam int SF = C_IN / SIMD;
    localparam int NF = C_OUT / PE;
    localparam int NW = C_OUT * SF;
    localparam int FW = fold_w(C_IN, SIMD);
    localparam int GW = grp_w(C_OUT, PE);
    localparam int AW = cnt_w(NW);

    if (!params_ok(C_IN, C_OUT, SIMD, PE, IN_WIDTH, W_WIDTH, ACC_WIDTH)) begin : g_bad_params
        $error("interface_relationships_mvu: illegal parameter combination");
    end

    mvu_state_e r_state, w_next;
    logic [AW-1:0] r_wcnt;
    logic [FW-1:0] r_icnt, r_fold;
    logic [GW-1:0] r_grp;
    logic          r_err;

    // Weight RAM and vector buffer carry no reset: a fresh load is forced by the FSM instead.
    logic [SIMD*W_WIDTH-1:0]  r_wmem [NW];
    logic [SIMD*IN_WIDTH-1:0] r_xbuf [SF];

    logic w_wfire, w_ifire, w_ofire, w_reload;
    logic w_wlast, w_ilast, w_flast, w_glast;
    logic [PE-1:0][SIMD*W_WIDTH-1:0] w_wrows;
    logic [PE-1:0][ACC_WIDTH-1:0]    w_acc, w_lane;

    assign w_wlast  = (r_wcnt == AW'(NW - 1));
    assign w_ilast  = (r_icnt == FW'(SF - 1));
    assign w_flast  = (r_fold == FW'(SF - 1));
    assign w_glast  = (r_grp == GW'(NF - 1));
    // Weights win only while no beat of the current vector has been taken.
    assign w_reload = (r_state == RX_IN) && (r_icnt == '0) && s_axis_weights_tvalid;

    assign s_axis_weights_tready = !ap_rst && (r_state == LOAD_W);
    assign s_axis_input_tready   = !ap_rst && (r_state == RX_IN) && !w_reload;
    assign m_axis_output_tvalid  = !ap_rst && (r_state == EMIT);
    assign m_axis_output_tlast   = m_axis_output_tvalid && w_glast;
    assign err_framing           = r_err;

    assign w_wfire = s_axis_weights_tvalid && s_axis_weights_tready;
    assign w_ifire = s_axis_input_tvalid && s_axis_input_tready;
    assign w_ofire = m_axis_output_tvalid && m_axis_output_tready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD_W:  if (w_wfire && w_wlast) w_next = RX_IN;
            RX_IN: begin
                if (w_reload)                w_next = LOAD_W;
                else if (w_ifire && w_ilast) w_next = COMPUTE;
            end
            COMPUTE: if (w_flast) w_next = EMIT;
            EMIT:    if (w_ofire) w_next = w_glast ? RX_IN : COMPUTE;
            default: w_next = LOAD_W;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= LOAD_W;
            r_wcnt  <= '0;
            r_icnt  <= '0;
            r_fold  <= '0;
            r_grp   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wfire) begin
                r_wcnt <= w_wlast ? '0 : r_wcnt + 1'b1;
                if (s_axis_weights_tlast != w_wlast) r_err <= 1'b1;
            end
            if (w_ifire) begin
                r_icnt <= w_ilast ? '0 : r_icnt + 1'b1;
                if (s_axis_input_tlast != w_ilast) r_err <= 1'b1;
            end
            if (r_state == COMPUTE) r_fold <= w_flast ? '0 : r_fold + 1'b1;
            if (w_ofire)            r_grp  <= w_glast ? '0 : r_grp + 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_wfire) r_wmem[r_wcnt] <= s_axis_weights_tdata;
        if (w_ifire) r_xbuf[r_icnt] <= s_axis_input_tdata;
    end

    // Row-major layout: row r, fold f lives at r*SF + f.
    for (genvar p = 0; p < PE; p++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr     = AW'((int'(r_grp) * PE + p) * SF + int'(r_fold));
        assign w_wrows[p] = r_wmem[w_addr];
    end

    mvu_pe_array #(
        .SIMD      (SIMD),
        .PE        (PE),
        .IN_WIDTH  (IN_WIDTH),
        .W_WIDTH   (W_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .IN_SIGNED (IN_SIGNED),
        .W_SIGNED  (W_SIGNED)
    ) u_pe_array (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .i_en  (r_state == COMPUTE),
        .i_clr (r_fold == '0),
        .i_x   (r_xbuf[r_fold]),
        .i_w   (w_wrows),
        .o_acc (w_acc)
    );

    for (genvar p = 0; p < PE; p++) begin : g_out
`ifdef MVU_RELU_EN
        assign w_lane[p] = w_acc[p][ACC_WIDTH-1] ? '0 : w_acc[p];
`else
        assign w_lane[p] = w_acc[p];
`endif
    end

    assign m_axis_output_tdata = ap_rst ? '0 : w_lane;

endmodule

// File: tb/tb_interface_relationships_mvu.sv
// Self-checking bench for interface_relationships_mvu (C_IN=C_OUT=4, SIMD=PE=2).
// A reference dot-product model fills a scoreboard queue; a monitor pops on each output handshake.
module tb_interface_relationships_mvu;
    localparam int C_IN = 4, C_OUT = 4, SIMD = 2, PE = 2;
    localparam int IW = 8, WW = 8, ACCW = 32;
    localparam int SF = C_IN / SIMD, NF = C_OUT / PE, NW = C_OUT * SF;

    logic                ap_clk = 1'b0;
    logic                ap_rst = 1'b1;
    logic [SIMD*WW-1:0]  s_axis_weights_tdata = '0;
    logic                s_axis_weights_tvalid = 1'b0;
    logic                s_axis_weights_tready;
    logic                s_axis_weights_tlast = 1'b0;
    logic [SIMD*IW-1:0]  s_axis_input_tdata = '0;
    logic                s_axis_input_tvalid = 1'b0;
    logic                s_axis_input_tready;
    logic                s_axis_input_tlast = 1'b0;
    logic [PE*ACCW-1:0]  m_axis_output_tdata;
    logic                m_axis_output_tvalid;
    logic                m_axis_output_tready = 1'b1;
    logic                m_axis_output_tlast;
    logic                err_framing;

    int n_cmp = 0;
    int n_bad = 0;
    int wm [C_OUT][C_IN];
    logic [PE*ACCW:0] q [$];

    always #5 ap_clk = ~ap_clk;

    interface_relationships_mvu #(
        .C_IN(C_IN), .C_OUT(C_OUT), .SIMD(SIMD), .PE(PE), .IN_WIDTH(IW), .W_WIDTH(WW),
        .ACC_WIDTH(ACCW), .IN_SIGNED(1), .W_SIGNED(1)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_weights_tdata(s_axis_weights_tdata), .s_axis_weights_tvalid(s_axis_weights_tvalid),
        .s_axis_weights_tready(s_axis_weights_tready), .s_axis_weights_tlast(s_axis_weights_tlast),
        .s_axis_input_tdata(s_axis_input_tdata), .s_axis_input_tvalid(s_axis_input_tvalid),
        .s_axis_input_tready(s_axis_input_tready), .s_axis_input_tlast(s_axis_input_tlast),
        .m_axis_output_tdata(m_axis_output_tdata), .m_axis_output_tvalid(m_axis_output_tvalid),
        .m_axis_output_tready(m_axis_output_tready), .m_axis_output_tlast(m_axis_output_tlast),
        .err_framing(err_framing)
    );

    // Scoreboard consumer: every output handshake must match the oldest expected beat.
    always @(negedge ap_clk) begin
        if (!ap_rst && m_axis_output_tvalid && m_axis_output_tready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected got=%h", {m_axis_output_tlast, m_axis_output_tdata});
            end else if ({m_axis_output_tlast, m_axis_output_tdata} !== q[0]) begin
                n_bad++;
                $display("FAIL out_beat got=%h exp=%h",
                         {m_axis_output_tlast, m_axis_output_tdata}, q[0]);
                void'(q.pop_front());
            end else begin
                void'(q.pop_front());
            end
        end
    end

    function automatic logic [ACCW-1:0] lane_val(input int v);
`ifdef MVU_RELU_EN
        return (v < 0) ? '0 : ACCW'(v);
`else
        return ACCW'(v);
`endif
    endfunction

    task automatic put_w_beat(input logic [SIMD*WW-1:0] d, input logic last);
        int n = 0;
        s_axis_weights_tdata  = d;
        s_axis_weights_tlast  = last;
        s_axis_weights_tvalid = 1'b1;
        forever begin
            @(negedge ap_clk);
            if (s_axis_weights_tready) break;
            n++;
            if (n > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL w_handshake_timeout waited=%0d cycles", n);
                break;
            end
        end
        @(posedge ap_clk); #1;
        s_axis_weights_tvalid = 1'b0;
        s_axis_weights_tlast  = 1'b0;
    endtask

    task automatic put_x_beat(input logic [SIMD*IW-1:0] d, input logic last);
        int n = 0;
        s_axis_input_tdata  = d;
        s_axis_input_tlast  = last;
        s_axis_input_tvalid = 1'b1;
        forever begin
            @(negedge ap_clk);
            if (s_axis_input_tready) break;
            n++;
            if (n > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL x_handshake_timeout waited=%0d cycles", n);
                break;
            end
        end
        @(posedge ap_clk); #1;
        s_axis_input_tvalid = 1'b0;
        s_axis_input_tlast  = 1'b0;
    endtask

    // Sends the first nb beats of wm; beat `bad` carries a spurious tlast.
    task automatic load_weights(input int bad, input int nb);
        logic [SIMD*WW-1:0] d;
        for (int b = 0; b < nb; b++) begin
            for (int s = 0; s < SIMD; s++) d[s*WW +: WW] = WW'(wm[b / SF][(b % SF) * SIMD + s]);
            put_w_beat(d, (b == NW - 1) || (b == bad));
        end
    endtask

    task automatic send_vec(input int x [C_IN], input int bad);
        logic [PE*ACCW:0] e;
        logic [SIMD*IW-1:0] d;
        int sum;
        for (int g = 0; g < NF; g++) begin
            e = '0;
            for (int p = 0; p < PE; p++) begin
                sum = 0;
                for (int k = 0; k < C_IN; k++) sum += wm[g*PE + p][k] * x[k];
                e[p*ACCW +: ACCW] = lane_val(sum);
            end
            e[PE*ACCW] = (g == NF - 1);
            q.push_back(e);
        end
        for (int f = 0; f < SF; f++) begin
            for (int s = 0; s < SIMD; s++) d[s*IW +: IW] = IW'(x[f*SIMD + s]);
            put_x_beat(d, (f == SF - 1) || (f == bad));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge ap_clk); #1;
            n++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout left=%0d required=0", q.size());
        end
    endtask

    task automatic rand_weights();
        for (int r = 0; r < C_OUT; r++)
            for (int k = 0; k < C_IN; k++) wm[r][k] = int'($urandom_range(255)) - 128;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        n_cmp += 5;
        if (s_axis_weights_tready !== 1'b0) begin n_bad++; $display("FAIL rst_wready got=%b exp=0", s_axis_weights_tready); end
        if (s_axis_input_tready !== 1'b0)   begin n_bad++; $display("FAIL rst_iready got=%b exp=0", s_axis_input_tready); end
        if (m_axis_output_tvalid !== 1'b0 || m_axis_output_tlast !== 1'b0) begin
            n_bad++; $display("FAIL rst_ovalid got=%b/%b exp=0/0", m_axis_output_tvalid, m_axis_output_tlast); end
        if (m_axis_output_tdata !== '0)     begin n_bad++; $display("FAIL rst_tdata got=%h exp=0", m_axis_output_tdata); end
        if (err_framing !== 1'b0)           begin n_bad++; $display("FAIL rst_err got=%b exp=0", err_framing); end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        n_cmp += 3;
        if (s_axis_weights_tready !== 1'b1) begin n_bad++; $display("FAIL post_rst_wready got=%b exp=1", s_axis_weights_tready); end
        if (s_axis_input_tready !== 1'b0)   begin n_bad++; $display("FAIL post_rst_iready got=%b exp=0", s_axis_input_tready); end
        if (m_axis_output_tvalid !== 1'b0 || m_axis_output_tdata !== '0) begin
            n_bad++; $display("FAIL post_rst_out got=%b/%h exp=0/0", m_axis_output_tvalid, m_axis_output_tdata); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_identity();
        int xv [C_IN];
        int lat = 0;
        for (int r = 0; r < C_OUT; r++)
            for (int k = 0; k < C_IN; k++) wm[r][k] = (r == k) ? 1 : 0;
        load_weights(-1, NW);
        xv = '{1, 2, 3, 4};
        send_vec(xv, -1);
        // Beat cycle is cycle 0; tvalid must show in cycle SF+1, i.e. SF edges later.
        while (!m_axis_output_tvalid && lat < 50) begin @(posedge ap_clk); #1; lat++; end
        n_cmp++;
        if (lat != SF) begin n_bad++; $display("FAIL latency got=%0d edges exp=%0d", lat, SF); end
        drain();
    endtask

    task automatic test_signed();
        int xv [C_IN];
        for (int r = 0; r < C_OUT; r++)
            for (int k = 0; k < C_IN; k++) wm[r][k] = -1;
        load_weights(-1, NW);
        xv = '{127, 127, 127, 127};
        send_vec(xv, -1);
        drain();
    endtask

    task automatic test_backpressure();
        int xv [C_IN];
        int n = 0;
        rand_weights();
        load_weights(-1, NW);
        xv = '{-7, 100, -128, 55};
        m_axis_output_tready = 1'b0;
        send_vec(xv, -1);
        while (!m_axis_output_tvalid && n < 50) begin @(posedge ap_clk); #1; n++; end
        repeat (10) begin
            @(negedge ap_clk);
            n_cmp += 2;
            if (m_axis_output_tvalid !== 1'b1 || {m_axis_output_tlast, m_axis_output_tdata} !== q[0]) begin
                n_bad++;
                $display("FAIL stall_hold got=%b/%h exp=1/%h", m_axis_output_tvalid,
                         {m_axis_output_tlast, m_axis_output_tdata}, q[0]);
            end
            if (s_axis_input_tready !== 1'b0) begin n_bad++; $display("FAIL stall_iready got=%b exp=0", s_axis_input_tready); end
        end
        @(posedge ap_clk); #1;
        m_axis_output_tready = 1'b1;
        drain();
    endtask

    task automatic test_random();
        int xv [C_IN];
        for (int i = 0; i < 3; i++) begin
            rand_weights();
            load_weights(-1, NW);
            for (int k = 0; k < C_IN; k++) xv[k] = int'($urandom_range(255)) - 128;
            send_vec(xv, -1);
            for (int k = 0; k < C_IN; k++) xv[k] = int'($urandom_range(255)) - 128;
            send_vec(xv, -1);
            drain();
        end
    endtask

    task automatic test_framing();
        int xv [C_IN];
        xv = '{3, -9, 27, -81};
        send_vec(xv, 0);
        drain();
        n_cmp++;
        if (err_framing !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b exp=1", err_framing); end
        xv = '{1, 1, 1, 1};
        send_vec(xv, -1);
        drain();
        n_cmp++;
        if (err_framing !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", err_framing); end
    endtask

    task automatic test_reload();
        int xv [C_IN];
        xv = '{10, -20, 30, -40};
        send_vec(xv, -1);
        drain();
        rand_weights();
        load_weights(-1, NW);
        send_vec(xv, -1);
        drain();
    endtask

    task automatic test_reset_midload();
        int xv [C_IN];
        rand_weights();
        load_weights(-1, 3);
        s_axis_weights_tdata  = 16'hA5A5;
        s_axis_weights_tvalid = 1'b1;
        ap_rst = 1'b1;
        @(negedge ap_clk);
        n_cmp += 2;
        if (s_axis_weights_tready !== 1'b0) begin n_bad++; $display("FAIL midrst_wready got=%b exp=0", s_axis_weights_tready); end
        if (m_axis_output_tdata !== '0 || m_axis_output_tvalid !== 1'b0) begin
            n_bad++; $display("FAIL midrst_out got=%b/%h exp=0/0", m_axis_output_tvalid, m_axis_output_tdata); end
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        s_axis_weights_tvalid = 1'b0;
        @(negedge ap_clk);
        n_cmp += 3;
        if (s_axis_weights_tready !== 1'b1) begin n_bad++; $display("FAIL midrst_load_w got=%b exp=1", s_axis_weights_tready); end
        if (s_axis_input_tready !== 1'b0)   begin n_bad++; $display("FAIL midrst_iready got=%b exp=0", s_axis_input_tready); end
        if (err_framing !== 1'b0)           begin n_bad++; $display("FAIL midrst_err got=%b exp=0", err_framing); end
        @(posedge ap_clk); #1;
        rand_weights();
        load_weights(3, NW);
        n_cmp++;
        if (err_framing !== 1'b1) begin n_bad++; $display("FAIL w_framing got=%b exp=1", err_framing); end
        xv = '{-128, 127, -1, 64};
        send_vec(xv, -1);
        drain();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_signed();
        test_backpressure();
        test_random();
        test_framing();
        test_reload();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/interface_relationships_mvu.md
INTERFACE_RELATIONSHIPS_MVU -- requirements
Module: interface_relationships_mvu

Interface
REQ-001 The module SHALL have the following parameters, one per line (name, default, meaning):
- C_IN, 32, input channels / vector length.
- C_OUT, 64, output channels.
- SIMD, 8, input elements per beat; C_IN % SIMD == 0.
- PE, 16, outputs computed in parallel; C_OUT % PE == 0.
- IN_WIDTH, 8, input element bits.
- W_WIDTH, 8, weight element bits.
- ACC_WIDTH, 32, accumulator/output element bits; must be >= IN_WIDTH+W_WIDTH+$clog2(C_IN).
- IN_SIGNED, 1, input elements are signed.
- W_SIGNED, 1, weights are signed.
REQ-002 The module SHALL have the following ports, one per line (name, direction, width, meaning):
- ap_clk, in, 1, sole clock.
- ap_rst, in, 1, synchronous active-high reset.
- s_axis_weights_tdata, in, SIMD*W_WIDTH, SIMD weights of one row; lane 0 in the LSBs.
- s_axis_weights_tvalid, in, 1, weight beat valid.
- s_axis_weights_tready, out, 1, weight beat accepted.
- s_axis_weights_tlast, in, 1, last beat of a weight set.
- s_axis_input_tdata, in, SIMD*IN_WIDTH, SIMD input elements.
- s_axis_input_tvalid / s_axis_input_tready / s_axis_input_tlast, in/out/in, 1 each, input handshake; tlast marks the last beat of a vector.
- m_axis_output_tdata, out, PE*ACC_WIDTH, PE results.
- m_axis_output_tvalid / m_axis_output_tready / m_axis_output_tlast, out/in/out, 1 each, output handshake; tlast marks the last beat of a result vector.
- err_framing, out, 1, sticky tlast-mismatch flag.
REQ-003 The design SHALL use one clock, ap_clk, and a synchronous active-high reset, ap_rst.

Function
REQ-004 A beat SHALL transfer only on a cycle where valid and ready are both high.
REQ-005 The FSM states SHALL be:
- LOAD_W: accept C_OUT*C_IN/SIMD weight beats, row-major, into the weight RAM.
- RX_IN: accept C_IN/SIMD input beats into the vector buffer.
- COMPUTE: step through the folds.
- EMIT: present one output beat.
REQ-006 Transitions: reset->LOAD_W; LOAD_W->RX_IN after the final weight beat; RX_IN->COMPUTE after the final input beat; COMPUTE->EMIT after C_IN/SIMD cycles; EMIT->COMPUTE on output handshake if PE groups remain; EMIT->RX_IN otherwise.
REQ-007 In RX_IN, when the vector buffer is empty and s_axis_weights_tvalid is high, the FSM SHALL enter LOAD_W instead (weight reload); input has priority once any input beat of the vector has been accepted.
REQ-008 s_axis_weights_tready SHALL be high only in LOAD_W; s_axis_input_tready SHALL be high only in RX_IN.
REQ-009 COMPUTE SHALL perform PE*SIMD MACs per cycle, with operands sign- or zero-extended per IN_SIGNED/W_SIGNED, accumulating in ACC_WIDTH with wrap-around on overflow.
REQ-010 Output lane p of group g SHALL equal sum over k of W[g*PE+p][k]*X[k].
REQ-011 m_axis_output_tdata and m_axis_output_tvalid SHALL remain stable while m_axis_output_tready is low; compute stalls meanwhile.
REQ-012 m_axis_output_tlast SHALL be high on group C_OUT/PE-1 only.
REQ-013 Latency from the last input beat to the first output tvalid SHALL be C_IN/SIMD+1 cycles.
REQ-014 Framing errors SHALL set err_framing without altering data flow:
- input tlast high on a non-final beat, or low on the final beat;
- weight tlast mismatched in the same way.
REQ-015 With PE=C_OUT and SIMD=C_IN, the module SHALL produce one output beat per vector.

Reset
REQ-016 Reset SHALL drive the FSM to LOAD_W and clear all counters and err_framing.
REQ-017 During and after reset, every valid/ready/tlast output SHALL be 0 and m_axis_output_tdata SHALL be 0.
REQ-018 Reset SHALL NOT clear the weight RAM contents, but loading SHALL be required again after reset.
REQ-019 Reset asserted mid-vector or mid-load SHALL discard the partial data.

Configuration
REQ-020 With MVU_RELU_EN defined, each output lane SHALL be clamped to 0 when negative (signed interpretation); without it, raw accumulator values SHALL be output.

Structure
REQ-021 Package mvu_pkg SHALL hold the FSM state enum, the fold/group counter width functions, and parameter legality checks.
REQ-022 The sub-module mvu_pe_array SHALL implement the combinational PE*SIMD multiply plus the registered accumulators.

Verification
REQ-023 Weights = identity (C_IN=C_OUT=4, SIMD=PE=2), input [1,2,3,4] -> outputs [1,2] then [3,4], tlast on the second beat.
REQ-024 Signed: weight -1 everywhere, input all 127 with C_IN=4 -> every lane = -508; with MVU_RELU_EN, every lane = 0.
REQ-025 Hold m_axis_output_tready low for 10 cycles -> tdata stable, no input accepted, then correct results.
REQ-026 Input tlast on beat 0 of 2 -> err_framing=1 and sticky; results still computed.
REQ-027 Reload weights between two vectors -> the second vector uses the new weights; reset mid-load -> tready low, FSM in LOAD_W, fresh load required.
